memory_tank_access: RTL and testbench
=====================================

# memory_tank_access

Serial access controller at the read/write end of a long-tank delay line. It tracks digit and minor-cycle timing from the tank's major-cycle sync and waits for the addressed word to emerge. It then drives the tank's clear/in/out gates: serial write data goes onto the tank input, and serial read data from the tank output is assembled into a parallel word for the order/arithmetic units.

## Interface
- ADDR_W, 5, short-word address width; tank holds 2**ADDR_W short words (32 = one long tank).
- r1_clk  in  1  digit clock; one serial digit per cycle.
- r1_rst_n  in  1  asynchronous active-low reset.
- r1_sync  in  1  major-cycle sync; high in the cycle digit 0 of minor cycle 0 is on r1_mob.
- r1_req  in  1  access request, level; sampled only in IDLE.
- r1_we  in  1  1 = write, 0 = read; latched with request.
- r1_long  in  1  1 = 35-bit long word at even address pair; latched.
- r1_addr  in  ADDR_W  short-word address; bit 0 ignored when r1_long=1.
- r1_wdata  in  35  write word, LSB first on the line; short write uses bits 16:0.
- r1_ack  out  1  one-cycle completion pulse.
- r1_busy  out  1  request accepted and not yet acked.
- r1_rdata  out  35  read word; short read zero-extends bits 16:0.
- r1_mob  in  1  serial bit emerging from tank.
- r1_mib  out  1  serial bit driven into tank.
- r1_tank_clr  out  1  clear gate (inhibit recirculation).
- r1_tank_in  out  1  input gate (accept r1_mib).
- r1_tank_out  out  1  output gate (read enable).
- r1_monitor  out  1  monitor CRT stream (see Configuration).

## Operation
- Counters: digit 0..17 (0..16 data, 17 gap/sandwich), minor 0..2**ADDR_W-1; both free-running and wrapping together.
- An r1_sync sampled high marks the current cycle as digit 0/minor 0, so the next cycle is digit 1/minor 0. Block becomes "synced" at the first sync.
- The misalign flag is internal. It is set when sync arrives while the counter is not at digit 0/minor 0 (already synced), and cleared when a transfer restarts.
- FSM states: IDLE, WAIT, XFER.
  - IDLE -> WAIT when r1_req=1 and synced. In that cycle, latch we/long/addr (addr[0] forced 0 if long)/wdata; clear r1_rdata to 0.
  - Not synced: the request is held off (no accept, r1_busy=0).
  - WAIT -> XFER in the cycle where minor==addr and digit==0. That cycle is transfer digit 0.
  - XFER lasts 17 cycles for short words (digit 0..16) and 35 cycles for long words (minor addr digits 0..17, then minor addr+1 digits 0..16). Transfer index i = 0..16 or 0..34.
  - XFER -> IDLE after the last index; r1_ack=1 in the following cycle.
- During a transfer cycle (combinational decode of state and counters):
  - write: r1_tank_clr=1, r1_tank_in=1, r1_mib=wdata[i];
  - read: r1_tank_out=1, rdata[i] <= r1_mob at the clock edge.
- Outside transfer cycles, all gates and r1_mib are 0; the tank recirculates itself.
- r1_busy=1 from the cycle after acceptance through the ack cycle inclusive.
- r1_rdata holds its value from the ack cycle until the next acceptance.
- r1_req is ignored while busy. If r1_req is still high in the first IDLE cycle after ack, it is a new request.
- Misaligned sync during WAIT or XFER: return to WAIT with the latched request kept, index reset, and rdata cleared. A partially written word is rewritten in full on the retry.

## Timing
- Reset values: r1_ack=0, r1_busy=0, r1_rdata=0, r1_mib=0, all gates 0, r1_monitor=0, state IDLE, counters 0, unsynced.
- Acceptance edge to first transfer cycle: 1 to 2**ADDR_W*18 cycles.
- r1_ack occurs exactly 1 cycle after the last transfer cycle.
- Back-to-back access of the word immediately following: no extra major cycle if addressed before its digit 0.
- Reset asserted mid-transfer: immediate return to reset values. The tank word is undefined for writes.

## Configuration
- MEMORY_MONITOR_EN defined: r1_monitor = r1_mob registered one cycle, forced 0 while unsynced. This feeds the CRT monitor.
- MEMORY_MONITOR_EN undefined: r1_monitor tied 0 and no flop instantiated.

## Test plan
- Reset then sync, short read at addr 5 with a tank model holding 0x0AAAA: the transfer starts at minor 5 digit 0. r1_tank_out is high for 17 cycles, then r1_ack pulses with r1_rdata=0x0AAAA and r1_busy drops after the ack.
- Short write 0x1FFFF at addr 31: clr/in/mib high for digits 0..16 of minor 31. A later read of addr 31 returns 0x1FFFF, and neighbouring words are unchanged.
- Long write 0x5_5555_5555 at addr 7 (treated as 6) then long read: index 17 is carried on digit 17 of minor 6. The read returns 0x5_5555_5555.
- Request before first sync: no acceptance and r1_busy=0. After sync, the request is accepted and completes.
- Misaligned sync injected mid-read: the transfer restarts on the new alignment. Exactly one r1_ack is produced, with correct data.
- With and without MEMORY_MONITOR_EN: r1_monitor equals r1_mob delayed 1 cycle when defined, and is constant 0 when undefined.

Source files
------------

// File: rtl/memory_tank_access.sv
// Serial read/write controller for one long-tank delay line: digit/minor timing from major-cycle sync,
// tank gate drive and serial/parallel word assembly. Optional CRT monitor tap via MEMORY_MONITOR_EN.
module memory_tank_access #(
    parameter int ADDR_W = 5
) (
    input  logic              r1_clk,
    input  logic              r1_rst_n,
    input  logic              r1_sync,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic              r1_long,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [34:0]       r1_wdata,
    output logic              r1_ack,
    output logic              r1_busy,
    output logic [34:0]       r1_rdata,
    input  logic              r1_mob,
    output logic              r1_mib,
    output logic              r1_tank_clr,
    output logic              r1_tank_in,
    output logic              r1_tank_out,
    output logic              r1_monitor
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_XFER = 2'd2
    } state_t;

    localparam logic [4:0] DIGIT_LAST = 5'd17;

    state_t            r_state;
    state_t            w_next_state;
    logic [4:0]        r_digit;
    logic [ADDR_W-1:0] r_minor;
    logic              r_synced;
    logic              r_we;
    logic              r_long;
    logic [ADDR_W-1:0] r_addr;
    logic [34:0]       r_wdata;
    logic [5:0]        r_idx;
    logic [5:0]        w_next_idx;
    logic [5:0]        w_idx;
    logic              w_xfer;
    logic              w_done;
    logic              w_accept;
    logic              w_misalign;
    logic [5:0]        w_last_idx;
    logic              r_ack;
    logic              r_busy;
    logic [34:0]       r_rdata;

    // A sync off the counter origin means the tank timing slipped; any access in flight restarts.
    assign w_misalign = r1_sync && r_synced && !((r_digit == 5'd0) && (r_minor == '0));
    assign w_accept   = (r_state == S_IDLE) && r1_req && r_synced && !r_busy;
    assign w_last_idx = r_long ? 6'd34 : 6'd16;

    // Digit/minor counters, realigned by every sync
    always_ff @(posedge r1_clk or negedge r1_rst_n) begin
        if (!r1_rst_n) begin
            r_digit  <= 5'd0;
            r_minor  <= '0;
            r_synced <= 1'b0;
        end else if (r1_sync) begin
            r_digit  <= 5'd1;
            r_minor  <= '0;
            r_synced <= 1'b1;
        end else if (r_digit == DIGIT_LAST) begin
            r_digit  <= 5'd0;
            r_minor  <= r_minor + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
            r_digit  <= r_digit + 5'd1;
        end
    end

    // FSM state and transfer index registers
    always_ff @(posedge r1_clk or negedge r1_rst_n) begin
        if (!r1_rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= 6'd0;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_next_idx;
        end
    end

    // Next state and transfer-cycle decode; the WAIT cycle that hits the word is transfer index 0
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        w_idx        = 6'd0;
        w_xfer       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = S_WAIT;
                    w_next_idx   = 6'd0;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_WAIT: begin
                if (w_misalign) begin
                    w_next_idx = 6'd0;
                end else if ((r_digit == 5'd0) && (r_minor == r_addr)) begin
                    w_xfer       = 1'b1;
                    w_idx        = 6'd0;
                    w_next_state = S_XFER;
                    w_next_idx   = 6'd1;
                end else begin
                    w_next_state = S_WAIT;
                end
            end
            S_XFER: begin
                if (w_misalign) begin
                    w_next_state = S_WAIT;
                    w_next_idx   = 6'd0;
                end else begin
                    w_xfer = 1'b1;
                    w_idx  = r_idx;
                    if (r_idx == w_last_idx) begin
                        w_next_state = S_IDLE;
                        w_next_idx   = 6'd0;
                        w_done       = 1'b1;
                    end else begin
                        w_next_idx = r_idx + 6'd1;
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_idx   = 6'd0;
            end
        endcase
    end

    assign r1_tank_clr = w_xfer && r_we;
    assign r1_tank_in  = w_xfer && r_we;
    assign r1_tank_out = w_xfer && !r_we;
    assign r1_mib      = w_xfer && r_we && r_wdata[w_idx];

    // Request latch; a long access always starts on the even word of the pair
    always_ff @(posedge r1_clk or negedge r1_rst_n) begin
        if (!r1_rst_n) begin
            r_we    <= 1'b0;
            r_long  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 35'd0;
        end else if (w_accept) begin
            r_we    <= r1_we;
            r_long  <= r1_long;
            r_addr  <= r1_long ? {r1_addr[ADDR_W-1:1], 1'b0} : r1_addr;
            r_wdata <= r1_wdata;
        end
    end

    // Read word assembly, cleared on acceptance and on a restart
    always_ff @(posedge r1_clk or negedge r1_rst_n) begin
        if (!r1_rst_n) begin
            r_rdata <= 35'd0;
        end else if (w_accept || (w_misalign && (r_state != S_IDLE))) begin
            r_rdata <= 35'd0;
        end else if (w_xfer && !r_we) begin
            r_rdata[w_idx] <= r1_mob;
        end
    end

    // Completion pulse and busy window (busy includes the ack cycle)
    always_ff @(posedge r1_clk or negedge r1_rst_n) begin
        if (!r1_rst_n) begin
            r_ack  <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_ack <= w_done;
            if (w_accept) begin
                r_busy <= 1'b1;
            end else if (r_ack) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign r1_ack   = r_ack;
    assign r1_busy  = r_busy;
    assign r1_rdata = r_rdata;

`ifdef MEMORY_MONITOR_EN
    logic r_monitor;

    // CRT monitor tap: tank output delayed one digit, silent until timing is known
    always_ff @(posedge r1_clk or negedge r1_rst_n) begin
        if (!r1_rst_n) begin
            r_monitor <= 1'b0;
        end else begin
            r_monitor <= r_synced && r1_mob;
        end
    end

    assign r1_monitor = r_monitor;
`else
    assign r1_monitor = 1'b0;
`endif

endmodule

// File: tb/tb_memory_tank_access.sv
// Bench for memory_tank_access: bit-level tank model, directed accesses, scoreboard checked on each ack.
module tb_memory_tank_access;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        r1_sync;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic        lng = 1'b0;
    logic [4:0]  addr = 5'd0;
    logic [34:0] wdata = 35'd0;
    logic        r1_ack;
    logic        r1_busy;
    logic [34:0] r1_rdata;
    logic        r1_mob;
    logic        r1_mib;
    logic        r1_tank_clr;
    logic        r1_tank_in;
    logic        r1_tank_out;
    logic        r1_monitor;

    logic        sync_en = 1'b0;
    logic        inject = 1'b0;
    int          pos = 100;
    logic        tank [0:575];

    int total = 0;
    int bad = 0;
    int n_ack = 0;

    typedef struct {
        logic [34:0] data;
        int          start;
        int          len;
        logic        is_wr;
    } exp_t;
    exp_t sb[$];

    memory_tank_access #(.ADDR_W(5)) dut (
        .r1_clk(clk), .r1_rst_n(rst_n), .r1_sync(r1_sync), .r1_req(req), .r1_we(we),
        .r1_long(lng), .r1_addr(addr), .r1_wdata(wdata), .r1_ack(r1_ack), .r1_busy(r1_busy),
        .r1_rdata(r1_rdata), .r1_mob(r1_mob), .r1_mib(r1_mib), .r1_tank_clr(r1_tank_clr),
        .r1_tank_in(r1_tank_in), .r1_tank_out(r1_tank_out), .r1_monitor(r1_monitor)
    );

    always #5 clk = ~clk;

    assign r1_sync = (sync_en && (pos == 0)) || inject;
    assign r1_mob  = tank[pos];

    // Tank position: any sync defines the current cycle as position 0
    always @(posedge clk) begin
        if (r1_sync) pos <= 1;
        else pos <= (pos == 575) ? 0 : pos + 1;
    end

    // Tank write: gated input replaces the recirculating bit
    always @(negedge clk) begin
        if (rst_n && r1_tank_clr && r1_tank_in) tank[pos] = r1_mib;
    end

    logic bsync = 1'b0;
    logic exp_mon = 1'b0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bsync <= 1'b0;
            exp_mon <= 1'b0;
        end else begin
            exp_mon <= bsync ? r1_mob : 1'b0;
            if (r1_sync) bsync <= 1'b1;
        end
    end

    // Monitor: collect gate activity, check against the scoreboard on every ack
    int          gcnt = 0;
    int          first = 0;
    logic        contig_bad = 1'b0;
    logic        gate_bad = 1'b0;
    logic [34:0] cap = 35'd0;
    logic        prev_ack = 1'b0;
    logic        mon_bad = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
`ifdef MEMORY_MONITOR_EN
            if (r1_monitor !== exp_mon) mon_bad = 1'b1;
`else
            if (r1_monitor !== 1'b0) mon_bad = 1'b1;
`endif
            if (r1_tank_clr !== r1_tank_in) gate_bad = 1'b1;
            if (r1_tank_in && r1_tank_out) gate_bad = 1'b1;
            if (!(r1_tank_in || r1_tank_out) && r1_mib) gate_bad = 1'b1;
            if (r1_sync && pos != 0) begin
                gcnt = 0; contig_bad = 1'b0; cap = 35'd0;
            end else if (r1_tank_in || r1_tank_out) begin
                if (gcnt == 0) first = pos;
                else if (pos != first + gcnt) contig_bad = 1'b1;
                if (gcnt < 35) cap[gcnt] = r1_mib;
                gcnt++;
            end
            if (prev_ack) begin
                total++;
                if (r1_busy !== 1'b0) begin
                    bad++;
                    $display("FAIL busy_after_ack: got %b want 0", r1_busy);
                end
            end
            if (r1_ack) begin
                n_ack++;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_ack: rdata=%h with empty scoreboard", r1_rdata);
                end else begin
                    exp_t e;
                    logic [34:0] got;
                    e = sb.pop_front();
                    got = e.is_wr ? cap : r1_rdata;
                    if (got !== e.data || first != e.start || gcnt != e.len || contig_bad || gate_bad) begin
                        bad++;
                        $display("FAIL access: data=%h start=%0d len=%0d contig_err=%b gate_err=%b want data=%h start=%0d len=%0d",
                                 got, first, gcnt, contig_bad, gate_bad, e.data, e.start, e.len);
                    end
                end
                gcnt = 0; contig_bad = 1'b0; gate_bad = 1'b0; cap = 35'd0;
            end
            prev_ack = r1_ack;
        end
    end

    task automatic set_word(input int w, input logic [34:0] v, input int nbits);
        for (int k = 0; k < nbits; k++) tank[(w * 18 + k) % 576] = v[k];
    endtask

    task automatic access(input logic a_we, input logic a_long, input logic [4:0] a_addr,
                          input logic [34:0] a_wd, input logic [34:0] a_rd,
                          input bit presync, input bit misalign);
        exp_t e;
        logic [4:0] eff;
        int n;
        bit seen_busy;
        eff = a_long ? {a_addr[4:1], 1'b0} : a_addr;
        e.is_wr = a_we;
        e.data  = a_we ? (a_long ? a_wd : {18'd0, a_wd[16:0]}) : a_rd;
        e.start = int'(eff) * 18;
        e.len   = a_long ? 35 : 17;
        sb.push_back(e);
        @(negedge clk);
        we = a_we; lng = a_long; addr = a_addr; wdata = a_wd; req = 1'b1;
        if (presync) begin
            seen_busy = 1'b0;
            repeat (30) begin
                @(negedge clk);
                if (r1_busy) seen_busy = 1'b1;
            end
            total++;
            if (seen_busy) begin
                bad++;
                $display("FAIL presync_hold: busy seen before sync, want none");
            end
            sync_en = 1'b1;
        end
        n = 0;
        while (!r1_busy && n < 1500) begin @(negedge clk); n++; end
        req = 1'b0;
        if (!r1_busy) begin
            total++; bad++;
            $display("FAIL accept_timeout: busy=%b after %0d cycles, want 1", r1_busy, n);
        end
        if (misalign) begin
            n = 0;
            while (!r1_tank_out && n < 1500) begin @(negedge clk); n++; end
            repeat (5) @(posedge clk);
            #1 inject = 1'b1;
            @(posedge clk);
            #1 inject = 1'b0;
        end
        n = 0;
        while (r1_busy && n < 1500) begin @(negedge clk); n++; end
        if (r1_busy) begin
            total++; bad++;
            $display("FAIL done_timeout: busy=%b after %0d cycles, want 0", r1_busy, n);
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 576; i++) tank[i] = 1'b0;
        set_word(0, 35'h0F0F0, 17);
        set_word(5, 35'h0AAAA, 17);
        tank[5 * 18 + 17] = 1'b1;
        set_word(30, 35'h12345, 17);
        set_word(31, 35'h1C3C3, 17);
        set_word(6, 35'h2_1234_5678, 35);

        repeat (3) @(negedge clk);
        total++;
        if ({r1_ack, r1_busy, r1_rdata, r1_mib, r1_tank_clr, r1_tank_in, r1_tank_out, r1_monitor} !== 41'd0) begin
            bad++;
            $display("FAIL reset_values: ack=%b busy=%b rdata=%h mib=%b clr=%b in=%b out=%b mon=%b want all 0",
                     r1_ack, r1_busy, r1_rdata, r1_mib, r1_tank_clr, r1_tank_in, r1_tank_out, r1_monitor);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        access(1'b0, 1'b0, 5'd5,  35'd0,           35'h0AAAA,       1'b1, 1'b0);
        access(1'b1, 1'b0, 5'd31, 35'h7_FFFF_FFFF, 35'd0,           1'b0, 1'b0);
        access(1'b0, 1'b0, 5'd31, 35'd0,           35'h1FFFF,       1'b0, 1'b0);
        access(1'b0, 1'b0, 5'd30, 35'd0,           35'h12345,       1'b0, 1'b0);
        access(1'b0, 1'b0, 5'd0,  35'd0,           35'h0F0F0,       1'b0, 1'b0);
        access(1'b1, 1'b1, 5'd7,  35'h5_5555_5555, 35'd0,           1'b0, 1'b0);
        total++;
        if (tank[6 * 18 + 17] !== 1'b0 || tank[7 * 18] !== 1'b1) begin
            bad++;
            $display("FAIL long_gap_bits: pos125=%b pos126=%b want 0 1", tank[6 * 18 + 17], tank[7 * 18]);
        end
        access(1'b0, 1'b1, 5'd6,  35'd0,           35'h5_5555_5555, 1'b0, 1'b0);
        access(1'b0, 1'b0, 5'd5,  35'd0,           35'h0AAAA,       1'b0, 1'b1);

        repeat (5) @(negedge clk);
        total++;
        if (sb.size() != 0 || n_ack != 8) begin
            bad++;
            $display("FAIL ack_count: acks=%0d pending=%0d want 8 0", n_ack, sb.size());
        end
        total++;
        if (mon_bad) begin
            bad++;
            $display("FAIL monitor_stream: got mismatching r1_monitor, want %s",
`ifdef MEMORY_MONITOR_EN
                     "mob delayed one cycle");
`else
                     "constant 0");
`endif
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
